// File: rtl/shmem_arbiter.sv
// Round-robin arbiter: NUM_REQ requesters share one synchronous memory port; IDLE->ISSUE->RESP, one access in flight.
// Optional atomic lock sequences are enabled by defining SHMEM_ARB_LOCK_EN (adds the req_lock input).
module shmem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef SHMEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 rr_cand;

  logic [NUM_REQ-1:0] ready_c;
  logic [NUM_REQ-1:0] rsp_valid_c;
  logic [DATA_W-1:0]  rsp_rdata_c;
  logic               mem_we_c;

`ifdef SHMEM_ARB_LOCK_EN
  logic               lock_act_q, lock_act_d;
  logic [IDX_W-1:0]   lock_own_q, lock_own_d;
  logic               lock_hold_q, lock_hold_d;

  // While a lock is held only its owner may compete.
  always_comb begin
    eligible = req_valid;
    if (lock_act_q) begin
      eligible = req_valid & (NUM_REQ'(1) << lock_own_q);
    end
  end
`else
  always_comb begin
    eligible = req_valid;
  end
`endif

  // Search starts one past the last grant and wraps, so the last winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_cand   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      rr_cand = int'(last_grant_q) + off;
      if (rr_cand >= NUM_REQ) begin
        rr_cand = rr_cand - NUM_REQ;
      end
      if (!win_found && eligible[IDX_W'(rr_cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(rr_cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    ready_c      = '0;
    rsp_valid_c  = '0;
    rsp_rdata_c  = '0;
    mem_we_c     = 1'b0;
`ifdef SHMEM_ARB_LOCK_EN
    lock_act_d   = lock_act_q;
    lock_own_d   = lock_own_q;
    lock_hold_d  = lock_hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          ready_c[win_idx] = 1'b1;
          last_grant_d     = win_idx;
          gnt_d            = win_idx;
          addr_d           = req_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_d          = req_wdata[win_idx*DATA_W +: DATA_W];
          we_d             = req_we[win_idx];
          state_d          = ST_ISSUE;
`ifdef SHMEM_ARB_LOCK_EN
          lock_hold_d = req_lock[win_idx];
          if (req_lock[win_idx]) begin
            lock_act_d = 1'b1;
            lock_own_d = win_idx;
          end
`endif
        end
      end
      ST_ISSUE: begin
        mem_we_c = we_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_c[gnt_q] = 1'b1;
        rsp_rdata_c        = mem_data_out;
        state_d            = ST_IDLE;
`ifdef SHMEM_ARB_LOCK_EN
        // An unlocked access by the owner closes the atomic sequence once it completes.
        if (lock_act_q && (lock_own_q == gnt_q) && !lock_hold_q) begin
          lock_act_d = 1'b0;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
`ifdef SHMEM_ARB_LOCK_EN
      lock_act_q   <= 1'b0;
      lock_own_q   <= '0;
      lock_hold_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
`ifdef SHMEM_ARB_LOCK_EN
      lock_act_q   <= lock_act_d;
      lock_own_q   <= lock_own_d;
      lock_hold_q  <= lock_hold_d;
`endif
    end
  end

  // Reset blanks every output immediately, including a write strobe already in ISSUE.
  assign req_ready   = rst ? '0   : ready_c;
  assign rsp_valid   = rst ? '0   : rsp_valid_c;
  assign rsp_rdata   = rst ? '0   : rsp_rdata_c;
  assign mem_we      = rst ? 1'b0 : mem_we_c;
  assign mem_addr    = rst ? '0   : addr_q;
  assign mem_data_in = rst ? '0   : wdata_q;

endmodule

// File: tb/tb_shmem_arbiter.sv
// Self-checking bench for shmem_arbiter: vector table, scoreboard of responses, hand sequences for corner cases.
module tb_shmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
`ifdef SHMEM_ARB_LOCK_EN
  logic [N-1:0]      req_lock;
`endif

  logic [AW-1:0]     addr_r[N];
  logic [DW-1:0]     wdata_r[N];
  logic [DW-1:0]     exp_r[N];

  typedef struct {
    logic [N-1:0]  onehot;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int            r;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int grant_cyc = 0;

  logic [DW-1:0] mem[64];
  bit            mem_init = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr_r[i];
      req_wdata[i*DW +: DW] = wdata_r[i];
    end
  end

  // Synchronous read-before-write memory, preloaded word i = i+1.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= DW'(i + 1);
      mem_init <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_data_in;
      mem_data_out <= mem[mem_addr[5:0]];
    end
  end

  shmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
`ifdef SHMEM_ARB_LOCK_EN
    .req_lock     (req_lock),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (!rst) begin
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_latency", 64'(cyc), 64'(e.cyc + 2));
          end
        end else begin
          chk("rdata_idle_zero", 64'(rsp_rdata), 64'd0);
        end
      end
    end
  endtask

  task automatic wait_grant(input bit push, output int w);
    exp_t e2;
    w = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
        grant_cyc = cyc;
        if (push) begin
          e2.onehot = N'(1) << w;
          e2.rdata  = exp_r[w];
          e2.cyc    = cyc;
          sb.push_back(e2);
        end
        break;
      end
    end
    if (w < 0) begin
      chk("grant_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask

  initial begin
    vec_t tbl[7];
    int   w, prev, wb;
    int   ord[5];

    fork
      monitor();
      forever begin @(posedge clk); cyc++; end
      begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
      end
    join_none

    for (int i = 0; i < N; i++) begin
      addr_r[i] = '0; wdata_r[i] = '0; exp_r[i] = '0;
    end
`ifdef SHMEM_ARB_LOCK_EN
    req_lock = '0;
`endif
    rst = 1'b1; req_we = '0;
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("idle_no_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;

    // Single-requester transactions, each drained before the next.
    tbl[0] = '{r: 1, we: 1'b0, addr: 32'd5, wd: 32'h0,    exp: 32'd6};
    tbl[1] = '{r: 2, we: 1'b1, addr: 32'd3, wd: 32'hDEAD, exp: 32'd4};
    tbl[2] = '{r: 0, we: 1'b0, addr: 32'd3, wd: 32'h0,    exp: 32'hDEAD};
    tbl[3] = '{r: 3, we: 1'b0, addr: 32'd0, wd: 32'h0,    exp: 32'd1};
    tbl[4] = '{r: 1, we: 1'b1, addr: 32'd0, wd: 32'h1234, exp: 32'd1};
    tbl[5] = '{r: 2, we: 1'b0, addr: 32'd0, wd: 32'h0,    exp: 32'h1234};
    tbl[6] = '{r: 3, we: 1'b0, addr: 32'd9, wd: 32'h0,    exp: 32'd10};
    for (int t = 0; t < 7; t++) begin
      addr_r[tbl[t].r]  = tbl[t].addr;
      wdata_r[tbl[t].r] = tbl[t].wd;
      exp_r[tbl[t].r]   = tbl[t].exp;
      req_we[tbl[t].r]  = tbl[t].we;
      req_valid[tbl[t].r] = 1'b1;
      wb = we_cnt;
      wait_grant(1'b1, w);
      req_valid = '0;
      chk("tbl_grant_id", 64'(w), 64'(tbl[t].r));
      wait_drain();
      req_we = '0;
      chk("tbl_mem_we_pulses", 64'(we_cnt - wb), 64'(tbl[t].we));
    end

    // All four requesting continuously after reset.
    do_reset();
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      addr_r[i] = AW'(10 + i);
      exp_r[i]  = DW'(11 + i);
    end
    req_valid = '1;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(1'b1, w);
      chk("rr_order", 64'(w), 64'(ord[g]));
      if (g > 0) chk("rr_spacing", 64'(grant_cyc - prev), 64'd3);
      prev = grant_cyc;
    end
    req_valid = '0;
    wait_drain();

    // Requester 3 alone, granted back-to-back across the wrap.
    addr_r[3] = 32'd20; exp_r[3] = 32'd21;
    req_valid[3] = 1'b1;
    wait_grant(1'b1, w);
    chk("wrap_first", 64'(w), 64'd3);
    prev = grant_cyc;
    wait_grant(1'b1, w);
    chk("wrap_second", 64'(w), 64'd3);
    chk("wrap_spacing", 64'(grant_cyc - prev), 64'd3);
    req_valid = '0;
    wait_drain();

    // Reset while a write sits in ISSUE: no write, no response, pointer restarts at 0.
    addr_r[2] = 32'd7; wdata_r[2] = 32'hBEEF; req_we[2] = 1'b1;
    req_valid[2] = 1'b1;
    wb = we_cnt;
    wait_grant(1'b0, w);
    chk("rstiss_grant", 64'(w), 64'd2);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("rstiss_mem_we", 64'(mem_we), 64'd0);
    chk("rstiss_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_we = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstiss_no_write", 64'(we_cnt - wb), 64'd0);
    chk("rstiss_addr7", 64'(mem[7]), 64'd8);
    for (int i = 0; i < N; i++) begin
      addr_r[i] = AW'(10 + i);
      exp_r[i]  = DW'(11 + i);
    end
    req_valid = '1;
    wait_grant(1'b1, w);
    req_valid = '0;
    chk("rstiss_next_grant", 64'(w), 64'd0);
    wait_drain();

`ifdef SHMEM_ARB_LOCK_EN
    // Locked read by 0, then its unlocked write, before pending requester 1.
    do_reset();
    addr_r[0] = 32'd2; exp_r[0] = 32'd3; req_lock[0] = 1'b1;
    addr_r[1] = 32'd2; exp_r[1] = 32'h77;
    req_valid = 4'b0011;
    wait_grant(1'b1, w);
    chk("lock_first", 64'(w), 64'd0);
    req_lock[0] = 1'b0; req_we[0] = 1'b1; wdata_r[0] = 32'h77; exp_r[0] = 32'd3;
    wait_grant(1'b1, w);
    chk("lock_second", 64'(w), 64'd0);
    req_valid[0] = 1'b0; req_we[0] = 1'b0;
    wait_grant(1'b1, w);
    chk("lock_third", 64'(w), 64'd1);
    req_valid = '0;
    wait_drain();
`endif

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
